// File: rtl/mic_pl_chain.sv
// -----------------------------------------------------------------------------
// mic_pl_chain
//
// Purpose:
//   Pipeline chain of double-buffered (skid) register stages for one MIC stream
//   channel (TDATA/TVALID/TREADY/TLAST). Every stage registers both the forward
//   path (data/valid/last) and the backward path (ready), so long valid/ready
//   timing paths are broken at each stage without losing throughput.
//   Packet content and ordering are preserved exactly.
//
// Parameters:
//   DEPTH  - number of skid stages (0..16). 0 gives a combinational wire-through.
//   DATA_W - TDATA width.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   I_TDATA    in   upstream beat data
//   I_TVALID   in   upstream beat valid
//   I_TREADY   out  chain can accept a beat (straight from stage 0's skid flop)
//   I_TLAST    in   upstream final beat of packet
//   O_TDATA    out  downstream beat data
//   O_TVALID   out  downstream beat valid
//   O_TREADY   in   downstream accepts the beat
//   O_TLAST    out  downstream final beat of packet
//
// Optional feature (macro MIC_PL_CHAIN_STATS_EN):
//   STAT_BEATS out  32-bit wrapping count of accepted output beats
//   STAT_PKTS  out  32-bit wrapping count of accepted output beats with TLAST
//   STAT_FULL  out  1 when every stage holds two beats
// -----------------------------------------------------------------------------
module mic_pl_chain #(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] I_TDATA,
    input  logic              I_TVALID,
    output logic              I_TREADY,
    input  logic              I_TLAST,
    output logic [DATA_W-1:0] O_TDATA,
    output logic              O_TVALID,
    input  logic              O_TREADY,
    output logic              O_TLAST
`ifdef MIC_PL_CHAIN_STATS_EN
    ,
    output logic [31:0]       STAT_BEATS,
    output logic [31:0]       STAT_PKTS,
    output logic [0:0]        STAT_FULL
`endif
);

`ifdef MIC_PL_CHAIN_STATS_EN
    logic w_all_full;
`endif

    generate
        if (DEPTH == 0) begin : g_wire
            // Pure wire-through: no state, both directions combinational.
            assign O_TDATA  = I_TDATA;
            assign O_TVALID = I_TVALID;
            assign O_TLAST  = I_TLAST;
            assign I_TREADY = O_TREADY;
`ifdef MIC_PL_CHAIN_STATS_EN
            // With no stages there is nothing to be full.
            assign w_all_full = 1'b0;
`endif
        end else begin : g_pipe
            // Chain links: index k is the input of stage k, index k+1 its output.
            logic [DEPTH:0]    w_vld;
            logic [DEPTH:0]    w_lst;
            logic [DEPTH:0]    w_rdy;
            logic [DATA_W-1:0] w_dat [DEPTH+1];
            logic [DEPTH-1:0]  w_full;

            assign w_vld[0]     = I_TVALID;
            assign w_dat[0]     = I_TDATA;
            assign w_lst[0]     = I_TLAST;
            assign w_rdy[DEPTH] = O_TREADY;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                // State flops (EMPTY = 00, HALF = 10, FULL = 11 as {m_v, s_v}).
                logic              r_m_v;
                logic              r_s_v;
                // Data flops: main and skid copies of data and last.
                logic [DATA_W-1:0] r_m_d;
                logic [DATA_W-1:0] r_s_d;
                logic              r_m_l;
                logic              r_s_l;

                logic w_wr;
                logic w_rd;
                logic w_m_v_next;
                logic w_s_v_next;
                logic w_ld_main_in;
                logic w_ld_skid;
                logic w_ld_main_skid;

                // A beat enters when offered and the skid slot is free; it
                // leaves when main holds a beat and the next stage is ready.
                assign w_wr = w_vld[gi] && !r_s_v;
                assign w_rd = r_m_v && w_rdy[gi+1];

                // State register: only the valid flags are reset.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_m_v <= 1'b0;
                        r_s_v <= 1'b0;
                    end else begin
                        r_m_v <= w_m_v_next;
                        r_s_v <= w_s_v_next;
                    end
                end

                // Next-state logic.
                always_comb begin
                    w_m_v_next = r_m_v;
                    w_s_v_next = r_s_v;
                    case ({r_m_v, r_s_v})
                        2'b00: begin
                            if (w_wr) w_m_v_next = 1'b1;
                        end
                        2'b10: begin
                            if (w_wr && !w_rd) begin
                                w_s_v_next = 1'b1;
                            end else if (!w_wr && w_rd) begin
                                w_m_v_next = 1'b0;
                            end
                        end
                        2'b11: begin
                            // Ready is low here, so only a read can happen.
                            if (w_rd) w_s_v_next = 1'b0;
                        end
                        default: begin
                            // Skid-only is unreachable; recover to empty.
                            w_m_v_next = 1'b0;
                            w_s_v_next = 1'b0;
                        end
                    endcase
                end

                // Output logic: data-path load strobes.
                always_comb begin
                    w_ld_main_in   = 1'b0;
                    w_ld_skid      = 1'b0;
                    w_ld_main_skid = 1'b0;
                    // New beat goes to main when main is empty or being drained
                    // this cycle; otherwise it parks in the skid slot.
                    if (w_wr && (!r_m_v || w_rd)) w_ld_main_in = 1'b1;
                    if (w_wr && r_m_v && !w_rd)   w_ld_skid    = 1'b1;
                    // When full and draining, the older skid beat moves forward.
                    if (r_s_v && w_rd)            w_ld_main_skid = 1'b1;
                end

                // Data registers carry no reset; they are qualified by r_m_v/r_s_v.
                always_ff @(posedge clk) begin
                    if (w_ld_main_in) begin
                        r_m_d <= w_dat[gi];
                        r_m_l <= w_lst[gi];
                    end else if (w_ld_main_skid) begin
                        r_m_d <= r_s_d;
                        r_m_l <= r_s_l;
                    end
                    if (w_ld_skid) begin
                        r_s_d <= w_dat[gi];
                        r_s_l <= w_lst[gi];
                    end
                end

                // Ready toward upstream comes directly from the skid flag flop.
                assign w_rdy[gi]    = !r_s_v;
                assign w_vld[gi+1]  = r_m_v;
                assign w_dat[gi+1]  = r_m_d;
                assign w_lst[gi+1]  = r_m_l;
                assign w_full[gi]   = r_m_v && r_s_v;
            end

            assign I_TREADY = w_rdy[0];
            assign O_TVALID = w_vld[DEPTH];
            assign O_TDATA  = w_dat[DEPTH];
            assign O_TLAST  = w_lst[DEPTH];

`ifdef MIC_PL_CHAIN_STATS_EN
            assign w_all_full = &w_full;
`else
            // Fullness is only consumed by the statistics block.
            logic w_full_unused;
            assign w_full_unused = &w_full;
`endif
        end
    endgenerate

`ifdef MIC_PL_CHAIN_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_pkts;

    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_beats <= 32'd0;
            r_stat_pkts  <= 32'd0;
        end else if (O_TVALID && O_TREADY) begin
            r_stat_beats <= r_stat_beats + 32'd1;
            if (O_TLAST) r_stat_pkts <= r_stat_pkts + 32'd1;
        end
    end

    assign STAT_BEATS = r_stat_beats;
    assign STAT_PKTS  = r_stat_pkts;
    assign STAT_FULL  = w_all_full;
`endif

endmodule

// File: tb/tb_mic_pl_chain.sv
// -----------------------------------------------------------------------------
// tb_mic_pl_chain
//
// Self-checking bench for mic_pl_chain (DEPTH=5, DATA_W=64). A FIFO scoreboard
// records every beat accepted at the input and every accepted output beat must
// match its head; outputs must be stable while valid && !ready, and no valid
// output may appear with nothing in flight. Directed tests add literal
// expectations for latency, throughput, capacity and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mic_pl_chain;

    localparam int DEPTH  = 5;
    localparam int DATA_W = 64;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] I_TDATA;
    logic              I_TVALID;
    logic              I_TREADY;
    logic              I_TLAST;
    logic [DATA_W-1:0] O_TDATA;
    logic              O_TVALID;
    logic              O_TREADY;
    logic              O_TLAST;
`ifdef MIC_PL_CHAIN_STATS_EN
    logic [31:0]       STAT_BEATS;
    logic [31:0]       STAT_PKTS;
    logic [0:0]        STAT_FULL;
`endif

    mic_pl_chain #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .I_TDATA  (I_TDATA),
        .I_TVALID (I_TVALID),
        .I_TREADY (I_TREADY),
        .I_TLAST  (I_TLAST),
        .O_TDATA  (O_TDATA),
        .O_TVALID (O_TVALID),
        .O_TREADY (O_TREADY),
        .O_TLAST  (O_TLAST)
`ifdef MIC_PL_CHAIN_STATS_EN
        ,
        .STAT_BEATS (STAT_BEATS),
        .STAT_PKTS  (STAT_PKTS),
        .STAT_FULL  (STAT_FULL)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model / scoreboard state ----------------
    logic [DATA_W:0] sb[$];          // {last, data} in acceptance order
    bit              in_fire  = 1'b0;
    bit              hold_v   = 1'b0;
    logic [DATA_W:0] hold_b;
    int              cyc      = 0;
    int              in_cnt   = 0;
    int              out_cnt  = 0;
    int              first_in_cyc  = -1;
    int              first_out_cyc = -1;
    int              last_in_cyc   = -1;
    int              last_out_cyc  = -1;
    logic [DATA_W:0] last_out_b;
    int              beats_m = 0;
    int              pkts_m  = 0;

    // Single compare process: sample mid-cycle, decide what transfers at the
    // following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            sb.delete();
            in_fire = 1'b0;
            hold_v  = 1'b0;
            beats_m = 0;
            pkts_m  = 0;
            chk(I_TREADY == 1'b1 && O_TVALID == 1'b0, "reset_state",
                {I_TREADY, O_TVALID}, 2'b10);
        end else begin
            if (hold_v)
                chk(O_TVALID == 1'b1 && {O_TLAST, O_TDATA} == hold_b, "stable_hold",
                    {O_TVALID, O_TLAST, O_TDATA}, {1'b1, hold_b});
            if (O_TVALID) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_valid", {O_TLAST, O_TDATA}, 0);
                end else begin
                    chk({O_TLAST, O_TDATA} == sb[0], "out_beat",
                        {O_TLAST, O_TDATA}, sb[0]);
                    if (O_TREADY) begin
                        void'(sb.pop_front());
                        out_cnt++;
                        beats_m++;
                        if (O_TLAST) pkts_m++;
                        if (first_out_cyc < 0) first_out_cyc = cyc;
                        last_out_cyc = cyc;
                        last_out_b   = {O_TLAST, O_TDATA};
                    end
                end
            end
            in_fire = I_TVALID && I_TREADY;
            if (in_fire) begin
                sb.push_back({I_TLAST, I_TDATA});
                in_cnt++;
                if (first_in_cyc < 0) first_in_cyc = cyc;
                last_in_cyc = cyc;
            end
            hold_v = O_TVALID && !O_TREADY;
            hold_b = {O_TLAST, O_TDATA};
        end
    end

    // ---------------- stimulus ----------------
    logic [DATA_W:0] src_mem [0:1023];
    int src_idx = 0;
    int src_n   = 0;
    int src_pct = 100;
    int snk_pct = 100;

    task automatic tick();
        @(posedge clk);
        #1;
        if (in_fire) src_idx++;
        if (I_TVALID && !in_fire) begin
            // offered beat not yet taken: keep it
        end else if (src_idx < src_n && $urandom_range(0, 99) < src_pct) begin
            I_TVALID = 1'b1;
            {I_TLAST, I_TDATA} = src_mem[src_idx];
        end else begin
            I_TVALID = 1'b0;
        end
        O_TREADY = ($urandom_range(0, 99) < snk_pct);
    endtask

    task automatic start_src(input int n);
        src_idx       = 0;
        src_n         = n;
        first_in_cyc  = -1;
        first_out_cyc = -1;
    endtask

    task automatic wait_out(input int target, input int budget, input string nm);
        int n = 0;
        while (out_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(out_cnt >= target, nm, out_cnt, target);
    endtask

    int in_base;
    int out_base;

    initial begin
        reset    = 1'b0;
        I_TVALID = 1'b0;
        I_TDATA  = '0;
        I_TLAST  = 1'b0;
        O_TREADY = 1'b0;

        // ---- reset ----
        repeat (3) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk(I_TREADY == 1'b1 && O_TVALID == 1'b0, "post_reset_edge",
            {I_TREADY, O_TVALID}, 2'b10);

        // ---- single beat latency ----
        src_mem[0] = {1'b1, 64'h0123456789ABCDEF};
        src_pct = 100;
        snk_pct = 100;
        start_src(1);
        wait_out(out_cnt + 1, 50, "single_timeout");
        chk(first_out_cyc - first_in_cyc == DEPTH, "single_latency",
            first_out_cyc - first_in_cyc, DEPTH);
        chk(last_out_b == {1'b1, 64'h0123456789ABCDEF}, "single_literal",
            last_out_b, {1'b1, 64'h0123456789ABCDEF});
`ifdef MIC_PL_CHAIN_STATS_EN
        chk(STAT_BEATS == 32'd1, "stat_beats_single", STAT_BEATS, 1);
        chk(STAT_PKTS == 32'd1, "stat_pkts_single", STAT_PKTS, 1);
`endif

        // ---- continuous 4-beat packets ----
        for (int i = 0; i < 20; i++)
            src_mem[i] = {(i % 4 == 3) ? 1'b1 : 1'b0, 64'(i)};
        out_base = out_cnt;
        start_src(20);
        wait_out(out_base + 20, 100, "stream_timeout");
        chk(last_in_cyc - first_in_cyc == 19, "stream_in_rate",
            last_in_cyc - first_in_cyc, 19);
        chk(last_out_cyc - first_out_cyc == 19, "stream_out_rate",
            last_out_cyc - first_out_cyc, 19);
        chk(last_out_b == {1'b1, 64'd19}, "stream_last_literal",
            last_out_b, {1'b1, 64'd19});

        // ---- capacity under backpressure ----
        for (int i = 0; i < 30; i++)
            src_mem[i] = {(i % 4 == 3) ? 1'b1 : 1'b0, 64'hC000 + 64'(i)};
        in_base  = in_cnt;
        out_base = out_cnt;
        snk_pct  = 0;
        start_src(30);
        repeat (30) tick();
        chk(in_cnt - in_base == 2 * DEPTH, "capacity_count", in_cnt - in_base, 2 * DEPTH);
        chk(I_TREADY == 1'b0, "capacity_ready", I_TREADY, 0);
`ifdef MIC_PL_CHAIN_STATS_EN
        chk(STAT_FULL == 1'b1, "stat_full", STAT_FULL, 1);
`endif
        snk_pct = 100;
        wait_out(out_base + 30, 200, "capacity_drain_timeout");
        chk(last_out_cyc - first_out_cyc == 29, "capacity_drain_rate",
            last_out_cyc - first_out_cyc, 29);
        chk(last_out_b == {1'b0, 64'hC000 + 64'd29}, "capacity_last_literal",
            last_out_b, {1'b0, 64'hC000 + 64'd29});

        // ---- random throttling on both sides ----
        for (int i = 0; i < 1000; i++)
            src_mem[i] = {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom, $urandom};
        out_base = out_cnt;
        src_pct  = 60;
        snk_pct  = 60;
        start_src(1000);
        wait_out(out_base + 1000, 20000, "random_timeout");
        src_pct = 100;
        snk_pct = 100;
        tick();

        // ---- reset with 6 beats in flight ----
        for (int i = 0; i < 6; i++)
            src_mem[i] = {(i == 5) ? 1'b1 : 1'b0, 64'hDEAD0000 + 64'(i)};
        in_base  = in_cnt;
        out_base = out_cnt;
        snk_pct  = 0;
        start_src(6);
        repeat (10) tick();
        chk(in_cnt - in_base == 6, "inflight_count", in_cnt - in_base, 6);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        I_TVALID = 1'b0;
        src_n    = src_idx;
        #1;
        chk(O_TVALID == 1'b0 && I_TREADY == 1'b1, "async_reset",
            {O_TVALID, I_TREADY}, 2'b01);
        repeat (2) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk(out_cnt == out_base, "no_flushed_out", out_cnt, out_base);
        for (int i = 0; i < 4; i++)
            src_mem[i] = {(i == 3) ? 1'b1 : 1'b0, 64'hBEEF0000 + 64'(i)};
        snk_pct = 100;
        start_src(4);
        wait_out(out_base + 4, 50, "post_reset_timeout");
        repeat (20) tick();
        chk(out_cnt - out_base == 4, "post_reset_count", out_cnt - out_base, 4);
        chk(last_out_b == {1'b1, 64'hBEEF0003}, "post_reset_literal",
            last_out_b, {1'b1, 64'hBEEF0003});
        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
`ifdef MIC_PL_CHAIN_STATS_EN
        chk(STAT_BEATS == 32'(beats_m), "stat_beats_end", STAT_BEATS, beats_m);
        chk(STAT_PKTS == 32'(pkts_m), "stat_pkts_end", STAT_PKTS, pkts_m);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
